// File: rtl/tc_pl_cap_crc_acc.sv
// Capture-path CRC-32/MPEG-2 accumulator: folds one DATA_W word per cycle, MSB first.
// Optional word counter / length check is built when CAP_CRC_WORD_CNT_EN is defined.
module tc_pl_cap_crc_acc #(
  parameter int CRC_W  = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              crc_en,
  input  logic [DATA_W-1:0] crc0_data,
  input  logic              crc0_data_valid,
  input  logic              tacp_cmpt,
`ifdef CAP_CRC_WORD_CNT_EN
  input  logic [31:0]       cap_len,
  output logic [31:0]       crc_word_cnt,
  output logic              crc_len_err,
`endif
  output logic [CRC_W-1:0]  crc_result,
  output logic              crc_done
);

  localparam logic [CRC_W-1:0] POLY = CRC_W'(32'h04C1_1DB7);
  localparam logic [CRC_W-1:0] INIT = {CRC_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FIN, S_DONE} state_t;

  state_t           state    = S_IDLE;
  logic [CRC_W-1:0] crc_q    = INIT;
  logic [CRC_W-1:0] result_q = '0;
  logic             done_q   = 1'b0;
  // Set only while crc_en is low, so a reset mid-transfer waits for a fresh enable.
  logic             armed    = 1'b0;

`ifdef CAP_CRC_WORD_CNT_EN
  logic [31:0] cnt_q     = '0;
  logic [31:0] cap_len_q = '0;
  logic        len_err_q = 1'b0;

  assign crc_word_cnt = cnt_q;
  assign crc_len_err  = len_err_q;
`endif

  assign crc_result = result_q;
  assign crc_done   = done_q;

  // Serial LFSR unrolled across the full word, bit DATA_W-1 entering first.
  function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] c_in,
                                            input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    c = c_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (c[CRC_W-1] ^ d[i]) c = (c << 1) ^ POLY;
      else                   c = c << 1;
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      crc_q    <= INIT;
      result_q <= '0;
      done_q   <= 1'b0;
      armed    <= 1'b0;
`ifdef CAP_CRC_WORD_CNT_EN
      cnt_q     <= '0;
      cap_len_q <= '0;
      len_err_q <= 1'b0;
`endif
    end else if (!crc_en) begin
      state    <= S_IDLE;
      crc_q    <= INIT;
      result_q <= '0;
      done_q   <= 1'b0;
      armed    <= 1'b1;
`ifdef CAP_CRC_WORD_CNT_EN
      cnt_q     <= '0;
      cap_len_q <= cap_len;
      len_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          crc_q <= INIT;
          if (armed) state <= S_ACC;
        end
        S_ACC: begin
          if (crc0_data_valid) begin
            crc_q <= fold(crc_q, crc0_data);
`ifdef CAP_CRC_WORD_CNT_EN
            if (cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
`endif
          end
          if (tacp_cmpt) state <= S_FIN;
        end
        S_FIN: begin
          result_q <= crc_q;
          done_q   <= 1'b1;
`ifdef CAP_CRC_WORD_CNT_EN
          len_err_q <= (cnt_q != cap_len_q);
`endif
          state    <= S_DONE;
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_pl_cap_crc_acc.sv
// Directed bench for tc_pl_cap_crc_acc; expected CRCs come from a byte-wise CRC-32/MPEG-2 model.
module tb_tc_pl_cap_crc_acc;

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic        clk = 1'b0;
  logic        rst;
  logic        crc_en;
  logic [63:0] crc0_data;
  logic        crc0_data_valid;
  logic        tacp_cmpt;
  logic [31:0] crc_result;
  logic        crc_done;
`ifdef CAP_CRC_WORD_CNT_EN
  logic [31:0] cap_len;
  logic [31:0] crc_word_cnt;
  logic        crc_len_err;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model;
  logic [31:0] held;
  int          gaps [16] = '{0, 1, 2, 3, 3, 0, 2, 1, 0, 0, 3, 1, 2, 2, 0, 1};

  tc_pl_cap_crc_acc #(.CRC_W(32), .DATA_W(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .crc_en          (crc_en),
    .crc0_data       (crc0_data),
    .crc0_data_valid (crc0_data_valid),
    .tacp_cmpt       (tacp_cmpt),
`ifdef CAP_CRC_WORD_CNT_EN
    .cap_len         (cap_len),
    .crc_word_cnt    (crc_word_cnt),
    .crc_len_err     (crc_len_err),
`endif
    .crc_result      (crc_result),
    .crc_done        (crc_done)
  );

  always #5 clk = ~clk;

  // Reference model: classic byte-at-a-time non-reflected CRC.
  function automatic logic [31:0] mdl_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {b, 24'h0};
    for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
    return c;
  endfunction

  function automatic logic [31:0] mdl_word(input logic [31:0] c_in, input logic [63:0] d);
    logic [31:0] c;
    c = c_in;
    for (int k = 7; k >= 0; k--) c = mdl_byte(c, d[8*k +: 8]);
    return c;
  endfunction

  function automatic logic [63:0] word_of(input int i);
    return (64'h9E37_79B9_7F4A_7C15 * 64'(i + 1)) ^ 64'hD1B5_4A32_D192_ED03;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start at a negedge and return at a later negedge.
  task automatic start_xfer(input logic idle_junk);
    crc_en = 1'b0; tacp_cmpt = 1'b0; crc0_data_valid = 1'b0;
    @(negedge clk);
    crc_en = 1'b1;
    if (idle_junk) begin
      crc0_data = 64'hDEAD_BEEF_0BAD_F00D;
      crc0_data_valid = 1'b1;
    end
    @(negedge clk);
    crc0_data_valid = 1'b0;
    model = 32'hFFFF_FFFF;
  endtask

  task automatic send_word(input logic [63:0] d);
    crc0_data = d;
    crc0_data_valid = 1'b1;
    model = mdl_word(model, d);
    @(negedge clk);
    crc0_data_valid = 1'b0;
  endtask

  task automatic finish_xfer(input string tag, input logic last_valid, input logic [63:0] d);
    tacp_cmpt = 1'b1;
    if (last_valid) begin
      crc0_data = d;
      crc0_data_valid = 1'b1;
      model = mdl_word(model, d);
    end
    @(negedge clk);
    crc0_data_valid = 1'b0;
    check({tag, "_done_fin"}, {31'b0, crc_done}, 32'd0);
    @(negedge clk);
    check({tag, "_done"}, {31'b0, crc_done}, 32'd1);
    check({tag, "_result"}, crc_result, model);
  endtask

  task automatic end_xfer(input string tag);
    crc_en = 1'b0;
    tacp_cmpt = 1'b0;
    @(negedge clk);
    check({tag, "_clr_done"}, {31'b0, crc_done}, 32'd0);
    check({tag, "_clr_result"}, crc_result, 32'd0);
  endtask

  initial begin
    logic [31:0] c;
    rst = 1'b1; crc_en = 1'b0; crc0_data = '0; crc0_data_valid = 1'b0; tacp_cmpt = 1'b0;
`ifdef CAP_CRC_WORD_CNT_EN
    cap_len = 32'd0;
`endif
    model = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check("rst_done", {31'b0, crc_done}, 32'd0);
    check("rst_result", crc_result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) c = mdl_byte(c, 8'h31 + 8'(i));
    check("model_check_value", c, 32'h0376_E6E7);

    // Empty transfer.
    start_xfer(1'b0);
    finish_xfer("empty", 1'b0, '0);
    check("empty_const", crc_result, 32'hFFFF_FFFF);
    end_xfer("empty");

    // Sixteen words with 0-3 idle cycles between them.
    start_xfer(1'b0);
    for (int i = 0; i < 16; i++) begin
      send_word(word_of(i));
      repeat (gaps[i]) @(negedge clk);
    end
    finish_xfer("gapped16", 1'b0, '0);
    end_xfer("gapped16");

    // Last word in the same cycle as tacp_cmpt.
    start_xfer(1'b0);
    send_word(word_of(20));
    send_word(word_of(21));
    finish_xfer("coincident", 1'b1, word_of(22));
    end_xfer("coincident");

    // Reset after 5 of 10 words, then a clean 10-word transfer.
    start_xfer(1'b0);
    for (int i = 0; i < 5; i++) send_word(word_of(30 + i));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_done", {31'b0, crc_done}, 32'd0);
    check("midrst_result", crc_result, 32'd0);
    start_xfer(1'b0);
    for (int i = 0; i < 10; i++) send_word(word_of(30 + i));
    finish_xfer("after_rst", 1'b0, '0);
    end_xfer("after_rst");

    // Valid pulses while idle and while done must not disturb the result.
    start_xfer(1'b1);
    send_word(64'h0123_4567_89AB_CDEF);
    send_word(64'hFFFF_FFFF_FFFF_FFFF);
    send_word(64'h0000_0000_0000_0000);
    finish_xfer("ignore", 1'b0, '0);
    held = model;
    crc0_data = 64'hCAFE_F00D_1234_5678;
    crc0_data_valid = 1'b1;
    @(negedge clk);
    crc0_data_valid = 1'b0;
    @(negedge clk);
    check("done_hold_result", crc_result, held);
    check("done_hold_done", {31'b0, crc_done}, 32'd1);
    end_xfer("ignore");

`ifdef CAP_CRC_WORD_CNT_EN
    cap_len = 32'd8;
    start_xfer(1'b0);
    for (int i = 0; i < 8; i++) send_word(word_of(40 + i));
    finish_xfer("len8", 1'b0, '0);
    check("len8_cnt", crc_word_cnt, 32'd8);
    check("len8_err", {31'b0, crc_len_err}, 32'd0);
    end_xfer("len8");
    check("len8_cnt_clr", crc_word_cnt, 32'd0);
    start_xfer(1'b0);
    for (int i = 0; i < 7; i++) send_word(word_of(40 + i));
    finish_xfer("len7", 1'b0, '0);
    check("len7_cnt", crc_word_cnt, 32'd7);
    check("len7_err", {31'b0, crc_len_err}, 32'd1);
    end_xfer("len7");
    check("len7_err_clr", {31'b0, crc_len_err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
